// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single register-file write port between the pipeline WB stage
// and a long-latency auxiliary unit (mult/div result return). Aux results are
// queued in a small FIFO. A busy scoreboard tracks the destination registers
// of issued aux ops and raises hazard_stall for RAW hazards in ID.
//
// Arbitration priority (combinational from registered state + requests):
//   1. FIFO head starved for STARVE_MAX cycles -> FIFO head, WB stalls
//   2. WB request with a non-zero destination    -> WB
//   3. FIFO non-empty                            -> FIFO head
//   4. (bypass build only) FIFO empty, live aux  -> aux result written directly
//
// Optional feature macro: RF_WRITE_ARBITER_BYPASS_EN
//   defined   : an aux result may be written in the cycle it arrives when the
//               FIFO is empty and WB does not want the port (zero latency).
//   undefined : every aux result goes through the FIFO (minimum latency 1).
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int DEPTH      = 2,  // aux FIFO entries, power of 2, >= 2
  parameter int STARVE_MAX = 4   // lost arbitration rounds before forcing
) (
  input  logic        clk,
  input  logic        reset,

  // WB stage
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,

  // aux unit result return
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_rd,
  input  logic [31:0] aux_data,

  // aux issue / ID-stage hazard check
  input  logic        aux_issue,
  input  logic [4:0]  aux_issue_rd,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        hazard_stall,

  // register file write port
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wdata
);

  // ---------------------------------------------------------------------------
  // Local parameters and types
  // ---------------------------------------------------------------------------
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

  // One queued register-file write.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_req_t;

  // Who owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_WB     = 2'd1,
    SRC_FIFO   = 2'd2,
    SRC_BYPASS = 2'd3
  } src_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wr_req_t           fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve_cnt;
  logic [31:1]       busy;        // register 0 has no busy bit

  // ---------------------------------------------------------------------------
  // Derived control
  // ---------------------------------------------------------------------------
  wr_req_t           head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              wb_req;
  logic              starved;
  logic              push;
  logic              pop;
  logic              bypass;
  src_e              grant;
  logic [31:1]       busy_next;
  logic [31:0]       busy_ext;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  // Ready comes from registered occupancy only: a full FIFO never accepts,
  // even if the head pops in the same cycle.
  assign aux_ready  = !fifo_full;

  // Writes to r0 are architecturally void, so they never compete for the port.
  assign wb_req     = wb_we && (wb_rd != 5'd0);

  assign starved    = !fifo_empty && (starve_cnt >= STARVE_LIM);

  // Arbitrate the write port; the register file is never written in reset.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    grant    = SRC_NONE;
    wb_stall = 1'b0;
    if (reset) begin
      grant = SRC_NONE;
    end else if (starved) begin
      grant    = SRC_FIFO;
      wb_stall = wb_req;
    end else if (wb_req) begin
      grant = SRC_WB;
    end else if (!fifo_empty) begin
      grant = SRC_FIFO;
`ifdef RF_WRITE_ARBITER_BYPASS_EN
    end else if (aux_valid && (aux_rd != 5'd0)) begin
      // FIFO is empty here, so aux_ready is high and the result can go
      // straight to the register file without being queued.
      grant = SRC_BYPASS;
`endif
    end
  end

  assign pop    = (grant == SRC_FIFO);
  assign bypass = (grant == SRC_BYPASS);

  // An aux result for r0 is accepted (handshake completes) but never stored.
  assign push   = aux_valid && aux_ready && (aux_rd != 5'd0) && !bypass;

  // Drive the register-file port from the granted source; zeros when idle.
  always_comb begin
    rf_we    = 1'b0;
    rf_wr    = 5'd0;
    rf_wdata = 32'd0;
    unique case (grant)
      SRC_WB: begin
        rf_we    = 1'b1;
        rf_wr    = wb_rd;
        rf_wdata = wb_data;
      end
      SRC_FIFO: begin
        rf_we    = 1'b1;
        rf_wr    = head.rd;
        rf_wdata = head.data;
      end
      SRC_BYPASS: begin
        rf_we    = 1'b1;
        rf_wr    = aux_rd;
        rf_wdata = aux_data;
      end
      default: begin
        rf_we    = 1'b0;
        rf_wr    = 5'd0;
        rf_wdata = 32'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Aux FIFO
  // ---------------------------------------------------------------------------

  // Store accepted aux results at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; validity is carried entirely by
    // the pointers and occupancy counter, which are reset.
    if (push) begin
      fifo_mem[wr_ptr] <= '{rd: aux_rd, data: aux_data};
    end
  end

  // Advance pointers and occupancy; a simultaneous push and pop leaves the
  // occupancy unchanged.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Count consecutive cycles the queued head lost the port; saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt < STARVE_LIM) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard
  // ---------------------------------------------------------------------------

  // Next busy vector: clear on an aux write to the register, then set on
  // issue, so a same-cycle set wins over the clear.
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < 32; i++) begin
      if (pop && (head.rd == 5'(i))) begin
        busy_next[i] = 1'b0;
      end
      if (bypass && (aux_rd == 5'(i))) begin
        busy_next[i] = 1'b0;
      end
      if (aux_issue && (aux_issue_rd == 5'(i))) begin
        busy_next[i] = 1'b1;
      end
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Hazard check uses registered busy only; bit 0 is tied low so r0 never
  // stalls.
  assign busy_ext     = {busy, 1'b0};
  assign hazard_stall = busy_ext[id_rs] | busy_ext[id_rt];

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_no_push_full : assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (reset)
    !(pop && fifo_empty));
  a_no_r0_write  : assert property (@(posedge clk) disable iff (reset)
    !(rf_we && (rf_wr == 5'd0)));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed scenario tasks drive rf_write_arbiter cycle by cycle. Every
// register-file write the bench expects is pushed to a per-source queue when
// the stimulus is driven; a negedge monitor pops and compares each write the
// DUT actually performs. Timing-specific expectations are checked inline.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        aux_issue;
  logic [4:0]  aux_issue_rd;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        hazard_stall;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wdata;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t wb_q[$];
  wr_t aux_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_stall     (wb_stall),
    .aux_valid    (aux_valid),
    .aux_ready    (aux_ready),
    .aux_rd       (aux_rd),
    .aux_data     (aux_data),
    .aux_issue    (aux_issue),
    .aux_issue_rd (aux_issue_rd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .hazard_stall (hazard_stall),
    .rf_we        (rf_we),
    .rf_wr        (rf_wr),
    .rf_wdata     (rf_wdata)
  );

  // Scoreboard monitor: every write must be the next expected WB or aux write;
  // an idle port must present zeros.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_tests++;
      if (rf_we === 1'b1) begin
        if (wb_q.size() > 0 && rf_wr === wb_q[0].rd && rf_wdata === wb_q[0].data) begin
          void'(wb_q.pop_front());
        end else if (aux_q.size() > 0 && rf_wr === aux_q[0].rd && rf_wdata === aux_q[0].data) begin
          void'(aux_q.pop_front());
        end else begin
          $display("FAIL sb_write got rd=%0d data=%h, not the next expected write (wb pending=%0d aux pending=%0d) t=%0t",
                   rf_wr, rf_wdata, wb_q.size(), aux_q.size(), $time);
          n_fail++;
        end
      end else if (rf_we !== 1'b0 || rf_wr !== 5'd0 || rf_wdata !== 32'd0) begin
        $display("FAIL sb_idle got we=%b rd=%0d data=%h exp we=0 rd=0 data=0 t=%0t",
                 rf_we, rf_wr, rf_wdata, $time);
        n_fail++;
      end
    end
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    wb_we        = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'd0;
    aux_valid    = 1'b0;
    aux_rd       = 5'd0;
    aux_data     = 32'd0;
    aux_issue    = 1'b0;
    aux_issue_rd = 5'd0;
    id_rs        = 5'd0;
    id_rt        = 5'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_we   = 1'b1;
    wb_rd   = rd;
    wb_data = data;
    wb_q.push_back('{rd: rd, data: data});
  endtask

  task automatic drive_aux(input logic [4:0] rd, input logic [31:0] data, input bit expect_write);
    aux_valid = 1'b1;
    aux_rd    = rd;
    aux_data  = data;
    if (expect_write) aux_q.push_back('{rd: rd, data: data});
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle();
    reset = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'hFFFF;
    aux_valid = 1'b1; aux_rd = 5'd4; aux_data = 32'h1;
    id_rs = 5'd1; id_rt = 5'd2;
    #2;
    if (rf_we !== 1'b0)        begin $display("FAIL reset_rf_we got=%b exp=0", rf_we); n_fail++; end n_tests++;
    if (rf_wr !== 5'd0)        begin $display("FAIL reset_rf_wr got=%0d exp=0", rf_wr); n_fail++; end n_tests++;
    if (rf_wdata !== 32'd0)    begin $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); n_fail++; end n_tests++;
    if (wb_stall !== 1'b0)     begin $display("FAIL reset_wb_stall got=%b exp=0", wb_stall); n_fail++; end n_tests++;
    if (hazard_stall !== 1'b0) begin $display("FAIL reset_hazard got=%b exp=0", hazard_stall); n_fail++; end n_tests++;
    if (aux_ready !== 1'b1)    begin $display("FAIL reset_aux_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    next_cycle();
    if (rf_we !== 1'b0)        begin $display("FAIL reset_held_rf_we got=%b exp=0", rf_we); n_fail++; end n_tests++;
    if (aux_ready !== 1'b1)    begin $display("FAIL reset_held_aux_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    idle();
    next_cycle();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wb_only();
    drive_wb(5'd8, 32'h1234);
    @(negedge clk);
    if (rf_we !== 1'b1)         begin $display("FAIL wb_only_we got=%b exp=1", rf_we); n_fail++; end n_tests++;
    if (rf_wr !== 5'd8)         begin $display("FAIL wb_only_wr got=%0d exp=8", rf_wr); n_fail++; end n_tests++;
    if (rf_wdata !== 32'h1234)  begin $display("FAIL wb_only_wdata got=%h exp=1234", rf_wdata); n_fail++; end n_tests++;
    if (wb_stall !== 1'b0)      begin $display("FAIL wb_only_stall got=%b exp=0", wb_stall); n_fail++; end n_tests++;
    next_cycle();
    // r0 destination: no write, no stall
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    @(negedge clk);
    if (rf_we !== 1'b0)         begin $display("FAIL wb_r0_we got=%b exp=0", rf_we); n_fail++; end n_tests++;
    if (wb_stall !== 1'b0)      begin $display("FAIL wb_r0_stall got=%b exp=0", wb_stall); n_fail++; end n_tests++;
    next_cycle();
    idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_aux_queued();
    logic exp_now;
`ifdef RF_WRITE_ARBITER_BYPASS_EN
    exp_now = 1'b1;
`else
    exp_now = 1'b0;
`endif
    drive_aux(5'd5, 32'hA5A5, 1'b1);
    @(negedge clk);
    if (aux_ready !== 1'b1)     begin $display("FAIL aux_push_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    if (rf_we !== exp_now)      begin $display("FAIL aux_push_cycle_we got=%b exp=%b", rf_we, exp_now); n_fail++; end n_tests++;
    next_cycle();
    idle();
    @(negedge clk);
    if (rf_we !== !exp_now)     begin $display("FAIL aux_n1_we got=%b exp=%b", rf_we, !exp_now); n_fail++; end n_tests++;
    if (!exp_now) begin
      if (rf_wr !== 5'd5)        begin $display("FAIL aux_n1_wr got=%0d exp=5", rf_wr); n_fail++; end n_tests++;
      if (rf_wdata !== 32'hA5A5) begin $display("FAIL aux_n1_wdata got=%h exp=a5a5", rf_wdata); n_fail++; end n_tests++;
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_starvation();
    drive_wb(5'd10, 32'h1000);
    drive_aux(5'd3, 32'h3333, 1'b1);
    @(negedge clk);
    if (rf_wr !== 5'd10)        begin $display("FAIL starve_c0_wr got=%0d exp=10", rf_wr); n_fail++; end n_tests++;
    next_cycle();
    aux_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive_wb(5'd10, 32'h1000 + 32'(k));
      @(negedge clk);
      if (rf_wr !== 5'd10 || rf_wdata !== 32'h1000 + 32'(k))
        begin $display("FAIL starve_wb_c%0d got rd=%0d data=%h exp rd=10 data=%h", k, rf_wr, rf_wdata, 32'h1000 + 32'(k)); n_fail++; end n_tests++;
      if (wb_stall !== 1'b0)    begin $display("FAIL starve_stall_c%0d got=%b exp=0", k, wb_stall); n_fail++; end n_tests++;
      next_cycle();
    end
    drive_wb(5'd10, 32'h1005);
    @(negedge clk);
    if (rf_wr !== 5'd3 || rf_wdata !== 32'h3333)
      begin $display("FAIL starve_forced got rd=%0d data=%h exp rd=3 data=3333", rf_wr, rf_wdata); n_fail++; end n_tests++;
    if (wb_stall !== 1'b1)      begin $display("FAIL starve_forced_stall got=%b exp=1", wb_stall); n_fail++; end n_tests++;
    next_cycle();
    // WB inputs held after the stall; already queued, so no new expectation
    @(negedge clk);
    if (rf_wr !== 5'd10 || rf_wdata !== 32'h1005)
      begin $display("FAIL starve_resume got rd=%0d data=%h exp rd=10 data=1005", rf_wr, rf_wdata); n_fail++; end n_tests++;
    if (wb_stall !== 1'b0)      begin $display("FAIL starve_resume_stall got=%b exp=0", wb_stall); n_fail++; end n_tests++;
    next_cycle();
    idle();
    @(negedge clk);
    if (rf_we !== 1'b0)         begin $display("FAIL starve_after_we got=%b exp=0", rf_we); n_fail++; end n_tests++;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full_rd0();
    // c0, c1: fill both entries under constant WB traffic
    drive_wb(5'd11, 32'h2000);
    drive_aux(5'd6, 32'h6666, 1'b1);
    @(negedge clk);
    if (aux_ready !== 1'b1)     begin $display("FAIL full_c0_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    next_cycle();
    drive_wb(5'd11, 32'h2001);
    drive_aux(5'd7, 32'h7777, 1'b1);
    @(negedge clk);
    if (aux_ready !== 1'b1)     begin $display("FAIL full_c1_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    next_cycle();
    // c2..c5: third result offered but held while full
    aux_valid = 1'b1; aux_rd = 5'd12; aux_data = 32'hCCCC;
    for (int k = 2; k <= 5; k++) begin
      drive_wb(5'd11, 32'h2000 + 32'(k));
      @(negedge clk);
      if (aux_ready !== 1'b0)   begin $display("FAIL full_c%0d_ready got=%b exp=0", k, aux_ready); n_fail++; end n_tests++;
      if (k < 5) next_cycle();
    end
    if (rf_wr !== 5'd6 || wb_stall !== 1'b1)
      begin $display("FAIL full_forced got rd=%0d stall=%b exp rd=6 stall=1", rf_wr, wb_stall); n_fail++; end n_tests++;
    next_cycle();
    // c6: held WB retried; slot freed so rd=12 is accepted
    @(negedge clk);
    if (aux_ready !== 1'b1)     begin $display("FAIL full_c6_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    if (rf_wr !== 5'd11 || rf_wdata !== 32'h2005)
      begin $display("FAIL full_c6_wb got rd=%0d data=%h exp rd=11 data=2005", rf_wr, rf_wdata); n_fail++; end n_tests++;
    aux_q.push_back('{rd: 5'd12, data: 32'hCCCC});
    next_cycle();
    // c7: WB idle, pop rd=7, FIFO full again
    idle();
    @(negedge clk);
    if (aux_ready !== 1'b0)     begin $display("FAIL full_c7_ready got=%b exp=0", aux_ready); n_fail++; end n_tests++;
    if (rf_wr !== 5'd7)         begin $display("FAIL full_c7_wr got=%0d exp=7", rf_wr); n_fail++; end n_tests++;
    next_cycle();
    // c8: simultaneous push rd=13 and pop rd=12
    drive_aux(5'd13, 32'hDDDD, 1'b1);
    @(negedge clk);
    if (aux_ready !== 1'b1)     begin $display("FAIL full_c8_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    if (rf_wr !== 5'd12)        begin $display("FAIL full_c8_wr got=%0d exp=12", rf_wr); n_fail++; end n_tests++;
    next_cycle();
    // c9: occupancy still 1; r0 result accepted and discarded while rd=13 pops
    drive_aux(5'd0, 32'hDEAD, 1'b0);
    @(negedge clk);
    if (aux_ready !== 1'b1)     begin $display("FAIL full_c9_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    if (rf_wr !== 5'd13)        begin $display("FAIL full_c9_wr got=%0d exp=13", rf_wr); n_fail++; end n_tests++;
    next_cycle();
    idle();
    @(negedge clk);
    if (rf_we !== 1'b0)         begin $display("FAIL full_rd0_we got=%b exp=0", rf_we); n_fail++; end n_tests++;
    if (aux_ready !== 1'b1)     begin $display("FAIL full_empty_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_scoreboard();
    aux_issue = 1'b1; aux_issue_rd = 5'd9; id_rs = 5'd9;
    @(negedge clk);
    if (hazard_stall !== 1'b0)  begin $display("FAIL sb_issue_cycle got=%b exp=0", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    aux_issue = 1'b0;
    @(negedge clk);
    if (hazard_stall !== 1'b1)  begin $display("FAIL sb_rs_busy got=%b exp=1", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    id_rs = 5'd0; id_rt = 5'd9;
    @(negedge clk);
    if (hazard_stall !== 1'b1)  begin $display("FAIL sb_rt_busy got=%b exp=1", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    // result for r9 queued behind WB traffic
    id_rs = 5'd9; id_rt = 5'd0;
    drive_wb(5'd14, 32'h7000);
    drive_aux(5'd9, 32'h9999, 1'b1);
    @(negedge clk);
    if (hazard_stall !== 1'b1)  begin $display("FAIL sb_push_cycle got=%b exp=1", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    // pop r9 while a new op re-issues r9: set wins
    wb_we = 1'b0; aux_valid = 1'b0;
    aux_issue = 1'b1; aux_issue_rd = 5'd9;
    @(negedge clk);
    if (rf_we !== 1'b1 || rf_wr !== 5'd9)
      begin $display("FAIL sb_pop got we=%b rd=%0d exp we=1 rd=9", rf_we, rf_wr); n_fail++; end n_tests++;
    if (hazard_stall !== 1'b1)  begin $display("FAIL sb_pop_cycle got=%b exp=1", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    aux_issue = 1'b0;
    @(negedge clk);
    if (hazard_stall !== 1'b1)  begin $display("FAIL sb_set_wins got=%b exp=1", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    drive_wb(5'd14, 32'h7001);
    drive_aux(5'd9, 32'h9998, 1'b1);
    next_cycle();
    wb_we = 1'b0; aux_valid = 1'b0;
    @(negedge clk);
    if (hazard_stall !== 1'b1)  begin $display("FAIL sb_clear_cycle got=%b exp=1", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    @(negedge clk);
    if (hazard_stall !== 1'b0)  begin $display("FAIL sb_cleared got=%b exp=0", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstream();
    drive_wb(5'd15, 32'h4000);
    drive_aux(5'd20, 32'h5555, 1'b0);
    aux_issue = 1'b1; aux_issue_rd = 5'd21;
    next_cycle();
    aux_issue = 1'b0;
    drive_wb(5'd15, 32'h4001);
    drive_aux(5'd22, 32'h6666, 1'b0);
    next_cycle();
    aux_valid = 1'b0;
    drive_wb(5'd15, 32'h4002);
    id_rs = 5'd21;
    @(negedge clk);
    if (aux_ready !== 1'b0)     begin $display("FAIL rstm_full got=%b exp=0", aux_ready); n_fail++; end n_tests++;
    if (hazard_stall !== 1'b1)  begin $display("FAIL rstm_busy got=%b exp=1", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    wb_we = 1'b0;
    reset = 1'b1;
    #1;
    if (rf_we !== 1'b0)         begin $display("FAIL rstm_we got=%b exp=0", rf_we); n_fail++; end n_tests++;
    if (aux_ready !== 1'b1)     begin $display("FAIL rstm_ready got=%b exp=1", aux_ready); n_fail++; end n_tests++;
    if (hazard_stall !== 1'b0)  begin $display("FAIL rstm_hazard got=%b exp=0", hazard_stall); n_fail++; end n_tests++;
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rf_we !== 1'b0)       begin $display("FAIL rstm_dropped_c%0d got we=%b rd=%0d exp we=0", k, rf_we, rf_wr); n_fail++; end n_tests++;
      next_cycle();
    end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_wb_only();
    test_aux_queued();
    test_starvation();
    test_full_rd0();
    test_scoreboard();
    test_reset_midstream();
    // every expected write must have been observed
    if (wb_q.size() !== 0)  begin $display("FAIL drain_wb pending=%0d exp=0", wb_q.size()); n_fail++; end n_tests++;
    if (aux_q.size() !== 0) begin $display("FAIL drain_aux pending=%0d exp=0", aux_q.size()); n_fail++; end n_tests++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
